// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response channel; master issues fetches, slave is the memory.
// Requests are valid/ready; responses return in request order with no backpressure.
interface if_fetch_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  imem_req_valid;
    logic                  imem_req_ready;
    logic [DATA_WIDTH-1:0] imem_req_addr;
    logic                  imem_rsp_valid;
    logic [DATA_WIDTH-1:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/if_fetch_unit.sv
// RV32I fetch stage: credit-limited in-order imem fetch, {pc,instr} queue to IF/ID, flush redirect.
// Request-to-valid_if latency 2 cycles with a 1-cycle memory; pc_en=0 holds the head, credit throttles requests.
module if_fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_dat_o,
    output logic [AW:0]      count_o
);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i && !clr_i && (count_q != FULL);
    assign do_pop  = pop_i && !clr_i && (count_q != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end

    assign head_dat_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;
endmodule

module if_fetch_unit #(
    parameter int                DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
    parameter int                FIFO_DEPTH = 2,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pc_en,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    if_fetch_unit_if.master       imem,
    output logic [DATA_WIDTH-1:0] instruction_if,
    output logic [DATA_WIDTH-1:0] pc_if,
    output logic                  valid_if
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW+1:0]       CREDIT_MAX = (CW + 2)'(FIFO_DEPTH);
    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~(DATA_WIDTH'(3));
    localparam logic [DATA_WIDTH-1:0] PC_STEP    = DATA_WIDTH'(4);

    logic [DATA_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]           drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]           inflight_cnt;
    logic [CW-1:0]           queue_cnt;
    logic [DATA_WIDTH-1:0]   inflight_pc;
    logic [2*DATA_WIDTH-1:0] queue_head;
    logic [CW+1:0]           used;
    logic                    credit;
    logic                    req_fire;
    logic                    rsp_drop;
    logic                    rsp_keep;
    logic                    queue_pop;

    // Registered counts only: a pop this cycle frees its slot next cycle.
    assign used   = {2'b00, queue_cnt} + {2'b00, inflight_cnt} + {2'b00, drop_cnt_q};
    assign credit = used < CREDIT_MAX;

    assign imem.imem_req_valid = !reset && !flush && credit;
    assign imem.imem_req_addr  = fetch_pc_q;
    assign req_fire            = imem.imem_req_valid && imem.imem_req_ready;

    assign rsp_drop  = imem.imem_rsp_valid && (drop_cnt_q != '0);
    assign rsp_keep  = imem.imem_rsp_valid && (drop_cnt_q == '0) && (inflight_cnt != '0) && !flush;
    assign queue_pop = pc_en && (queue_cnt != '0);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        drop_cnt_d = drop_cnt_q;
        if (flush) begin
            // Words still owed by memory, minus the one landing this cycle, are stale.
            fetch_pc_d = redirect_pc & ALIGN_MASK;
            drop_cnt_d = drop_cnt_q + inflight_cnt - {{(CW-1){1'b0}}, imem.imem_rsp_valid};
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + PC_STEP;
            if (rsp_drop) drop_cnt_d = drop_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    if_fetch_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_inflight (
        .clk        (clk),
        .rst        (reset),
        .clr_i      (flush),
        .push_i     (req_fire),
        .push_dat_i (fetch_pc_q),
        .pop_i      (rsp_keep),
        .head_dat_o (inflight_pc),
        .count_o    (inflight_cnt)
    );

    if_fetch_fifo #(
        .WIDTH (2 * DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (reset),
        .clr_i      (flush),
        .push_i     (rsp_keep),
        .push_dat_i ({inflight_pc, imem.imem_rsp_data}),
        .pop_i      (queue_pop),
        .head_dat_o (queue_head),
        .count_o    (queue_cnt)
    );

    assign valid_if       = (queue_cnt != '0);
    assign pc_if          = valid_if ? queue_head[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
    assign instruction_if = valid_if ? queue_head[DATA_WIDTH-1:0] : NOP_INSTR;
endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: in-order memory model returning addr^K, scoreboard on requests and pops.
module tb_if_fetch_unit;
    localparam logic [31:0] K   = 32'h5A5A_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_en;
    logic        flush;
    logic [31:0] redirect_pc;
    logic [31:0] instruction_if;
    logic [31:0] pc_if;
    logic        valid_if;

    if_fetch_unit_if #(.DATA_WIDTH(32)) imem ();

    if_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .pc_en          (pc_en),
        .flush          (flush),
        .redirect_pc    (redirect_pc),
        .imem           (imem.master),
        .instruction_if (instruction_if),
        .pc_if          (pc_if),
        .valid_if       (valid_if)
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic        hold;
    logic [31:0] pend[$];
    logic [31:0] exp_req;
    logic [31:0] exp_pc;
    logic        saw_zero;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: scoreboard at negedge, then the memory model responds just after posedge.
    task automatic step();
        logic        fire;
        logic [31:0] a;
        @(negedge clk);
        fire = imem.imem_req_valid && imem.imem_req_ready;
        a    = imem.imem_req_addr;
        if (fire) begin
            chk("req_addr", a, exp_req);
            exp_req = exp_req + 32'd4;
        end
        if (valid_if && pc_en && !flush) begin
            chk("pop_pc", pc_if, exp_pc);
            chk("pop_instr", instruction_if, exp_pc ^ K);
            if (pc_if == 32'h0) saw_zero = 1'b1;
            exp_pc = exp_pc + 32'd4;
        end
        @(posedge clk);
        #1;
        if (reset) begin
            pend.delete();
            imem.imem_rsp_valid = 1'b0;
        end else begin
            if (fire) pend.push_back(a);
            if (!hold && pend.size() > 0) begin
                imem.imem_rsp_valid = 1'b1;
                imem.imem_rsp_data  = pend.pop_front() ^ K;
            end else begin
                imem.imem_rsp_valid = 1'b0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; pc_en = 1'b1; flush = 1'b0; redirect_pc = '0;
        imem.imem_req_ready = 1'b1; imem.imem_rsp_valid = 1'b0; imem.imem_rsp_data = '0;
        hold = 1'b0; exp_req = '0; exp_pc = '0; saw_zero = 1'b0;

        // Reset state and first-fetch latency
        #1;
        chk("rst_valid", valid_if, 0);
        chk("rst_instr", instruction_if, NOP);
        chk("rst_pc", pc_if, 0);
        chk("rst_req_valid", imem.imem_req_valid, 0);
        step(); step();
        chk("rst_req_valid_held", imem.imem_req_valid, 0);
        reset = 1'b0; #1;
        chk("first_req_valid", imem.imem_req_valid, 1);
        chk("first_req_addr", imem.imem_req_addr, 32'h0);
        step();
        chk("valid_not_yet", valid_if, 0);
        step();
        chk("first_valid", valid_if, 1);
        chk("first_pc", pc_if, 32'h0);
        chk("first_instr", instruction_if, 32'h0 ^ K);
        chk("credit_full", imem.imem_req_valid, 0);

        // Stall with PC 0x8 at the head
        for (int i = 0; i < 20 && !(valid_if && pc_if == 32'h8); i++) step();
        chk("reach_pc8", pc_if, 32'h8);
        pc_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("stall_valid", valid_if, 1);
            chk("stall_pc", pc_if, 32'h8);
            chk("stall_instr", instruction_if, 32'h8 ^ K);
            chk("stall_req_valid", imem.imem_req_valid, 0);
        end
        pc_en = 1'b1;
        repeat (10) step();

        // Flush with one request in flight whose word arrives after the flush
        imem.imem_req_ready = 1'b0;
        repeat (5) step();
        chk("drained", valid_if, 0);
        hold = 1'b1; imem.imem_req_ready = 1'b1;
        step();
        imem.imem_req_ready = 1'b0; #1;
        chk("one_inflight_credit", imem.imem_req_valid, 1);
        flush = 1'b1; redirect_pc = 32'h0000_0103; hold = 1'b0; imem.imem_req_ready = 1'b1;
        exp_req = 32'h100; exp_pc = 32'h100; #1;
        chk("flush_no_req", imem.imem_req_valid, 0);
        step();
        flush = 1'b0; #1;
        chk("post_flush_valid", valid_if, 0);
        chk("post_flush_instr", instruction_if, NOP);
        chk("post_flush_pc", pc_if, 0);
        chk("post_flush_req_valid", imem.imem_req_valid, 1);
        chk("post_flush_req_addr", imem.imem_req_addr, 32'h100);
        for (int i = 0; i < 10 && !valid_if; i++) step();
        chk("redirect_pc_if", pc_if, 32'h100);
        chk("redirect_instr", instruction_if, 32'h100 ^ K);

        // Flush coinciding with a returning word and pc_en=1
        for (int i = 0; i < 10 && !(imem.imem_rsp_valid && valid_if); i++) step();
        chk("t4_setup", imem.imem_rsp_valid && valid_if, 1);
        flush = 1'b1; redirect_pc = 32'h0000_0200; exp_req = 32'h200; exp_pc = 32'h200;
        step();
        flush = 1'b0; #1;
        chk("t4_valid_after", valid_if, 0);
        chk("t4_req_valid", imem.imem_req_valid, 1);
        chk("t4_req_addr", imem.imem_req_addr, 32'h200);
        step();
        chk("t4_drop_zero_credit", imem.imem_req_valid, 1);
        chk("t4_next_addr", imem.imem_req_addr, 32'h204);
        for (int i = 0; i < 10 && !valid_if; i++) step();
        chk("t4_restart_pc", pc_if, 32'h200);
        repeat (6) step();

        // PC wrap at the top of the address space
        flush = 1'b1; redirect_pc = 32'hFFFF_FFF9; exp_req = 32'hFFFF_FFF8; exp_pc = 32'hFFFF_FFF8;
        saw_zero = 1'b0;
        step();
        flush = 1'b0; #1;
        chk("wrap_req_addr", imem.imem_req_addr, 32'hFFFF_FFF8);
        repeat (14) step();
        chk("wrap_pop_zero", saw_zero, 1);

        // Asynchronous reset with two requests outstanding
        hold = 1'b1;
        repeat (6) step();
        chk("two_inflight_no_credit", imem.imem_req_valid, 0);
        #2;
        reset = 1'b1; pend.delete(); imem.imem_rsp_valid = 1'b0; hold = 1'b0;
        #1;
        chk("async_rst_valid", valid_if, 0);
        chk("async_rst_instr", instruction_if, NOP);
        chk("async_rst_pc", pc_if, 0);
        chk("async_rst_req_valid", imem.imem_req_valid, 0);
        step(); step();
        reset = 1'b0; exp_req = '0; exp_pc = '0; hold = 1'b1; #1;
        chk("rerst_req_valid", imem.imem_req_valid, 1);
        chk("rerst_req_addr", imem.imem_req_addr, 32'h0);
        step();
        chk("rerst_credit1", imem.imem_req_valid, 1);
        chk("rerst_addr4", imem.imem_req_addr, 32'h4);
        step();
        chk("rerst_credit_exhausted", imem.imem_req_valid, 0);
        hold = 1'b0;
        repeat (10) step();
        chk("rerst_stream_progress", exp_pc >= 32'h8, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
